// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit.
// Holds the opcodes, FSM states and datapath select codes used by the controller and its timer.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_ALU_WB,
        S_BRANCH,
        S_JALR_ADDR,
        S_JAL,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10,
        SRC_A_ZERO  = 2'b11
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALU     = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        TC_NONE    = 2'b00,
        TC_ILLEGAL = 2'b01,
        TC_TIMEOUT = 2'b10
    } trap_cause_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Per-state wait counter producing the memory-access done and timeout conditions.
// The counter restarts on every controller state change and saturates so long waits never wrap.
module mem_wait_timer #(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned MEM_LAT       = 2,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic mem_ready_i,
    output logic done_o,
    output logic timeout_o
);

    localparam int unsigned MAXV = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
    localparam int unsigned CW   = $clog2(MAXV + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(MAXV)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready arriving on the limit cycle wins, so timeout is masked by mem_ready.
    if (MEM_HANDSHAKE != 0) begin : g_handshake
        assign done_o    = mem_ready_i;
        assign timeout_o = (TIMEOUT != 0) && !mem_ready_i && (cnt_q == CW'(TIMEOUT));
    end else begin : g_fixed
        logic unused_ready;
        assign unused_ready = mem_ready_i;
        assign done_o       = (cnt_q == CW'(MEM_LAT - 1));
        assign timeout_o    = 1'b0;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM: sequences fetch/decode/execute/memory/writeback on a shared datapath,
// traps on illegal opcodes and memory timeouts, and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_HANDSHAKE = 1,
    parameter int unsigned MEM_LAT       = 2,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             mem_ready,
    input  logic             trap_clr,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             reg_write,
    output logic             instr_done,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    state_e            state_q;
    state_e            state_d;
    trap_cause_e       cause_q;
    trap_cause_e       cause_d;
    logic [CNT_W-1:0]  count_q;

    logic              done;
    logic              timeout;
    logic              state_change;

    logic              req;
    logic              we;
    logic              addr_sel;
    logic              ir_wr;
    logic              pc_wr;
    logic              br;
    alu_src_a_e        src_a;
    alu_src_b_e        src_b;
    alu_op_e           op;
    result_src_e       res;
    logic              rf_wr;
    logic              retire;

    // Loads and stores are told apart by opcode alone; funct3 is carried for the datapath.
    logic              unused_funct3;
    assign unused_funct3 = ^funct3;

    assign state_change = (state_d != state_q);

    mem_wait_timer #(
        .MEM_HANDSHAKE (MEM_HANDSHAKE),
        .MEM_LAT       (MEM_LAT),
        .TIMEOUT       (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (state_change),
        .mem_ready_i (mem_ready),
        .done_o      (done),
        .timeout_o   (timeout)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
                if (done) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (state_q == S_MEM_READ) begin
                        state_d = S_MEM_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                    cause_d = TC_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADDR;
                    OP_LUI, OP_AUIPC:  state_d = S_EXEC_U;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = TC_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_WB:    state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_EXEC_U:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JALR_ADDR: state_d = S_JAL;
            S_JAL:       state_d = S_ALU_WB;
            S_TRAP: begin
                if (trap_clr) begin
                    state_d = S_FETCH;
                    cause_d = TC_NONE;
                end
            end
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cause_q <= TC_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Moore decode of the current state; only the strobes that complete an access look at done.
    always_comb begin
        req      = 1'b0;
        we       = 1'b0;
        addr_sel = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        br       = 1'b0;
        src_a    = SRC_A_PC;
        src_b    = SRC_B_RS2;
        op       = ALU_ADD;
        res      = RES_ALUOUT;
        rf_wr    = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                req   = 1'b1;
                src_b = SRC_B_FOUR;
                res   = RES_ALU;
                ir_wr = done;
                pc_wr = done;
            end
            S_DECODE: begin
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_IMM;
            end
            S_MEM_ADDR, S_JALR_ADDR: begin
                src_a = SRC_A_RS1;
                src_b = SRC_B_IMM;
            end
            S_MEM_READ: begin
                req      = 1'b1;
                addr_sel = 1'b1;
            end
            S_MEM_WB: begin
                res    = RES_MEMDATA;
                rf_wr  = 1'b1;
                retire = 1'b1;
            end
            S_MEM_WRITE: begin
                req      = 1'b1;
                we       = 1'b1;
                addr_sel = 1'b1;
                retire   = done;
            end
            S_EXEC_R: begin
                src_a = SRC_A_RS1;
                op    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                src_a = SRC_A_RS1;
                src_b = SRC_B_IMM;
                op    = ALU_ITYPE;
            end
            S_EXEC_U: begin
                if (opcode == OP_LUI) begin
                    src_a = SRC_A_ZERO;
                end else begin
                    src_a = SRC_A_OLDPC;
                end
                src_b = SRC_B_IMM;
            end
            S_ALU_WB: begin
                rf_wr  = 1'b1;
                retire = 1'b1;
            end
            S_BRANCH: begin
                src_a  = SRC_A_RS1;
                op     = ALU_BRANCH;
                br     = 1'b1;
                retire = 1'b1;
            end
            S_JAL: begin
                src_a = SRC_A_OLDPC;
                src_b = SRC_B_FOUR;
                pc_wr = 1'b1;
            end
            default: ;
        endcase
    end

    // rst_n gates every output so a reset mid-access drops the request without waiting for a clock.
    assign mem_req     = rst_n & req;
    assign mem_we      = rst_n & we;
    assign iord        = rst_n & addr_sel;
    assign ir_write    = rst_n & ir_wr;
    assign pc_write    = rst_n & pc_wr;
    assign branch      = rst_n & br;
    assign alu_src_a   = rst_n ? src_a : 2'b00;
    assign alu_src_b   = rst_n ? src_b : 2'b00;
    assign alu_op      = rst_n ? op : 2'b00;
    assign result_src  = rst_n ? res : 2'b00;
    assign reg_write   = rst_n & rf_wr;
    assign instr_done  = rst_n & retire;
    assign trap        = rst_n & (state_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control: a handshake instance with a short timeout
// and a fixed-latency instance, driven from a table of per-cycle inputs and expected outputs.
module tb_multicycle_control;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct {
        bit          doReset;
        bit          useB;
        logic [6:0]  op;
        logic        rdy;
        logic        clr;
        logic [18:0] exp;
        int unsigned cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        mem_ready;
    logic        trap_clr;

    // Output vector layout: mem_req mem_we iord ir_write pc_write branch a[2] b[2] op[2] res[2] reg_write instr_done trap cause[2]
    wire  [18:0] aVec;
    wire  [18:0] bVec;
    logic [31:0] aCount;
    logic [31:0] bCount;

    int testsRun    = 0;
    int testsFailed = 0;

    vec_t vecs[$];

    logic [18:0] eFetchW, eFetchD, eDecode, eExecR, eExecI, eLui, eAuipc, eAluWb;
    logic [18:0] eMemAddr, eMemRd, eMemWb, eMemWrW, eMemWrD, eBranch, eJal, eTrapIll, eTrapTo;

    always #5 clk = ~clk;

    multicycle_control #(
        .MEM_HANDSHAKE (1),
        .MEM_LAT       (2),
        .TIMEOUT       (4),
        .CNT_W         (32)
    ) dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .mem_ready   (mem_ready),
        .trap_clr    (trap_clr),
        .mem_req     (aVec[18]),
        .mem_we      (aVec[17]),
        .iord        (aVec[16]),
        .ir_write    (aVec[15]),
        .pc_write    (aVec[14]),
        .branch      (aVec[13]),
        .alu_src_a   (aVec[12:11]),
        .alu_src_b   (aVec[10:9]),
        .alu_op      (aVec[8:7]),
        .result_src  (aVec[6:5]),
        .reg_write   (aVec[4]),
        .instr_done  (aVec[3]),
        .trap        (aVec[2]),
        .trap_cause  (aVec[1:0]),
        .instr_count (aCount)
    );

    multicycle_control #(
        .MEM_HANDSHAKE (0),
        .MEM_LAT       (2),
        .TIMEOUT       (255),
        .CNT_W         (32)
    ) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .mem_ready   (mem_ready),
        .trap_clr    (trap_clr),
        .mem_req     (bVec[18]),
        .mem_we      (bVec[17]),
        .iord        (bVec[16]),
        .ir_write    (bVec[15]),
        .pc_write    (bVec[14]),
        .branch      (bVec[13]),
        .alu_src_a   (bVec[12:11]),
        .alu_src_b   (bVec[10:9]),
        .alu_op      (bVec[8:7]),
        .result_src  (bVec[6:5]),
        .reg_write   (bVec[4]),
        .instr_done  (bVec[3]),
        .trap        (bVec[2]),
        .trap_cause  (bVec[1:0]),
        .instr_count (bCount)
    );

    function automatic logic [18:0] mk(input logic mreq, input logic mwe, input logic io,
                                       input logic irw, input logic pcw, input logic br,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] rs,
                                       input logic rw, input logic idone, input logic tr,
                                       input logic [1:0] cause);
        return {mreq, mwe, io, irw, pcw, br, a, b, op, rs, rw, idone, tr, cause};
    endfunction

    task automatic addRow(input bit rst, input bit useB, input logic [6:0] op, input logic rdy,
                          input logic clr, input logic [18:0] exp, input int unsigned cnt);
        vec_t v;
        v.doReset = rst;
        v.useB    = useB;
        v.op      = op;
        v.rdy     = rdy;
        v.clr     = clr;
        v.exp     = exp;
        v.cnt     = cnt;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit sync, input logic [6:0] op, input logic rdy, input logic clr);
        if (sync) @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        trap_clr  = clr;
        #1;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        mem_ready = 1'b0;
        trap_clr  = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("reset A outputs", {13'b0, aVec}, 32'd0);
        checkOutput("reset A count", aCount, 32'd0);
        checkOutput("reset B outputs", {13'b0, bVec}, 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        funct3    = 3'd0;
        mem_ready = 1'b0;
        trap_clr  = 1'b0;

        eFetchW  = mk(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0, 2'b00);
        eFetchD  = mk(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0, 2'b00);
        eDecode  = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0,0, 2'b00);
        eExecR   = mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0,0, 2'b00);
        eExecI   = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b11,2'b00, 0,0,0, 2'b00);
        eLui     = mk(0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0,0,0, 2'b00);
        eAuipc   = mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0,0, 2'b00);
        eAluWb   = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0, 2'b00);
        eMemAddr = mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0,0, 2'b00);
        eMemRd   = mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 2'b00);
        eMemWb   = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b01, 1,1,0, 2'b00);
        eMemWrW  = mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 2'b00);
        eMemWrD  = mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0, 2'b00);
        eBranch  = mk(0,0,0,0,0,1, 2'b10,2'b00,2'b01,2'b00, 0,1,0, 2'b00);
        eJal     = mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0,0,0, 2'b00);
        eTrapIll = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1, 2'b01);
        eTrapTo  = mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1, 2'b10);

        // R-type with memory ready on the first fetch cycle
        addRow(1,0,OP_R,1,0,eFetchD,0);
        addRow(0,0,OP_R,0,0,eDecode,0);
        addRow(0,0,OP_R,0,0,eExecR,0);
        addRow(0,0,OP_R,0,0,eAluWb,0);
        // Load with ready delayed 3 cycles in fetch and in the read; trap_clr outside TRAP has no effect
        addRow(0,0,OP_LD,0,1,eFetchW,1);
        addRow(0,0,OP_LD,0,0,eFetchW,1);
        addRow(0,0,OP_LD,0,0,eFetchW,1);
        addRow(0,0,OP_LD,1,0,eFetchD,1);
        addRow(0,0,OP_LD,0,0,eDecode,1);
        addRow(0,0,OP_LD,0,0,eMemAddr,1);
        addRow(0,0,OP_LD,0,0,eMemRd,1);
        addRow(0,0,OP_LD,0,0,eMemRd,1);
        addRow(0,0,OP_LD,0,0,eMemRd,1);
        addRow(0,0,OP_LD,1,0,eMemRd,1);
        addRow(0,0,OP_LD,0,0,eMemWb,1);
        // JALR: address phase, then JAL link, then writeback
        addRow(0,0,OP_JALR,1,0,eFetchD,2);
        addRow(0,0,OP_JALR,0,0,eDecode,2);
        addRow(0,0,OP_JALR,0,0,eMemAddr,2);
        addRow(0,0,OP_JALR,0,0,eJal,2);
        addRow(0,0,OP_JALR,0,0,eAluWb,2);
        // I-type, LUI, AUIPC
        addRow(0,0,OP_I,1,0,eFetchD,3);
        addRow(0,0,OP_I,0,0,eDecode,3);
        addRow(0,0,OP_I,0,0,eExecI,3);
        addRow(0,0,OP_I,0,0,eAluWb,3);
        addRow(0,0,OP_LUI,1,0,eFetchD,4);
        addRow(0,0,OP_LUI,0,0,eDecode,4);
        addRow(0,0,OP_LUI,0,0,eLui,4);
        addRow(0,0,OP_LUI,0,0,eAluWb,4);
        addRow(0,0,OP_AUIPC,1,0,eFetchD,5);
        addRow(0,0,OP_AUIPC,0,0,eDecode,5);
        addRow(0,0,OP_AUIPC,0,0,eAuipc,5);
        addRow(0,0,OP_AUIPC,0,0,eAluWb,5);
        // Branch retires in its own cycle
        addRow(0,0,OP_BR,1,0,eFetchD,6);
        addRow(0,0,OP_BR,0,0,eDecode,6);
        addRow(0,0,OP_BR,0,0,eBranch,6);
        // Store with one wait cycle
        addRow(0,0,OP_ST,1,0,eFetchD,7);
        addRow(0,0,OP_ST,0,0,eDecode,7);
        addRow(0,0,OP_ST,0,0,eMemAddr,7);
        addRow(0,0,OP_ST,0,0,eMemWrW,7);
        addRow(0,0,OP_ST,1,0,eMemWrD,7);
        // JAL
        addRow(0,0,OP_JAL,1,0,eFetchD,8);
        addRow(0,0,OP_JAL,0,0,eDecode,8);
        addRow(0,0,OP_JAL,0,0,eJal,8);
        addRow(0,0,OP_JAL,0,0,eAluWb,8);
        // Illegal opcode traps, holds until trap_clr, no retirement
        addRow(0,0,OP_BAD,1,0,eFetchD,9);
        addRow(0,0,OP_BAD,0,0,eDecode,9);
        addRow(0,0,OP_BAD,1,0,eTrapIll,9);
        addRow(0,0,OP_BAD,0,1,eTrapIll,9);
        // Fetch timeout after the counter reaches 4 with ready low
        addRow(0,0,OP_BAD,0,0,eFetchW,9);
        addRow(0,0,OP_BAD,0,0,eFetchW,9);
        addRow(0,0,OP_BAD,0,0,eFetchW,9);
        addRow(0,0,OP_BAD,0,0,eFetchW,9);
        addRow(0,0,OP_BAD,0,0,eFetchW,9);
        addRow(0,0,OP_BAD,0,0,eTrapTo,9);
        addRow(0,0,OP_BAD,0,1,eTrapTo,9);
        // Ready on the limit cycle beats the timeout
        addRow(0,0,OP_LD,1,0,eFetchD,9);
        addRow(0,0,OP_LD,0,0,eDecode,9);
        addRow(0,0,OP_LD,0,0,eMemAddr,9);
        addRow(0,0,OP_LD,0,0,eMemRd,9);
        addRow(0,0,OP_LD,0,0,eMemRd,9);
        addRow(0,0,OP_LD,0,0,eMemRd,9);
        addRow(0,0,OP_LD,0,0,eMemRd,9);
        addRow(0,0,OP_LD,1,0,eMemRd,9);
        addRow(0,0,OP_LD,0,0,eMemWb,9);
        // Read timeout
        addRow(0,0,OP_LD,1,0,eFetchD,10);
        addRow(0,0,OP_LD,0,0,eDecode,10);
        addRow(0,0,OP_LD,0,0,eMemAddr,10);
        addRow(0,0,OP_LD,0,0,eMemRd,10);
        addRow(0,0,OP_LD,0,0,eMemRd,10);
        addRow(0,0,OP_LD,0,0,eMemRd,10);
        addRow(0,0,OP_LD,0,0,eMemRd,10);
        addRow(0,0,OP_LD,0,0,eMemRd,10);
        addRow(0,0,OP_LD,0,0,eTrapTo,10);
        addRow(0,0,OP_LD,0,1,eTrapTo,10);
        addRow(0,0,OP_LD,0,0,eFetchW,10);
        // Fixed latency of 2: mem_ready is ignored
        addRow(1,1,OP_ST,1,0,eFetchW,0);
        addRow(0,1,OP_ST,0,0,eFetchD,0);
        addRow(0,1,OP_ST,1,0,eDecode,0);
        addRow(0,1,OP_ST,0,0,eMemAddr,0);
        addRow(0,1,OP_ST,1,0,eMemWrW,0);
        addRow(0,1,OP_ST,0,0,eMemWrD,0);
        addRow(0,1,OP_ST,1,0,eFetchW,1);
        addRow(0,1,OP_ST,0,0,eFetchD,1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].doReset) resetPulse();
            applyStimulus(!vecs[i].doReset, vecs[i].op, vecs[i].rdy, vecs[i].clr);
            if (vecs[i].useB) begin
                checkOutput($sformatf("row%0d B outputs", i), {13'b0, bVec}, {13'b0, vecs[i].exp});
                checkOutput($sformatf("row%0d B count", i), bCount, vecs[i].cnt);
            end else begin
                checkOutput($sformatf("row%0d A outputs", i), {13'b0, aVec}, {13'b0, vecs[i].exp});
                checkOutput($sformatf("row%0d A count", i), aCount, vecs[i].cnt);
            end
        end

        // Asynchronous reset in the middle of a read wait
        resetPulse();
        applyStimulus(0, OP_LD, 1, 0);
        checkOutput("midrst fetch", {13'b0, aVec}, {13'b0, eFetchD});
        applyStimulus(1, OP_LD, 0, 0);
        applyStimulus(1, OP_LD, 0, 0);
        applyStimulus(1, OP_LD, 0, 0);
        checkOutput("midrst read wait", {13'b0, aVec}, {13'b0, eMemRd});
        #1;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checkOutput("midrst outputs zero", {13'b0, aVec}, 32'd0);
        checkOutput("midrst count zero", aCount, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst back in fetch", {13'b0, aVec}, {13'b0, eFetchW});
        applyStimulus(1, OP_LD, 1, 0);
        checkOutput("midrst fetch resumes", {13'b0, aVec}, {13'b0, eFetchD});
        checkOutput("midrst no completion", aCount, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
